// File: rtl/req_ack_pkg.sv
// Shared types and constants for the REQ/ACK sender endpoint.
package req_ack_pkg;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      WAIT_ACK_HI = 2'd1,
      WAIT_ACK_LO = 2'd2,
      WAIT_TOGGLE = 2'd3
   } state_t;

   localparam int PHASES_4 = 4;
   localparam int PHASES_2 = 2;

endpackage

// File: rtl/cdc_sync_bit.sv
// Multi-flop synchroniser for a single bit arriving from another clock domain.
module cdc_sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   // Shift the raw bit one stage further down the chain each cycle
   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   // Chain flops clear to 0 so the far side looks idle out of reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/req_ack_sender_fifo.sv
// REQ/ACK sender endpoint with a small upstream FIFO, 4-phase or 2-phase
// signalling. Optional ack-timeout flag enabled by macro REQACK_TIMEOUT_EN.
module req_ack_sender_fifo
   import req_ack_pkg::*;
#(
   parameter int DWIDTH         = 8,
   parameter int DEPTH          = 4,
   parameter int PHASES         = 4,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                       clk1,
   input  logic                       rst1_n,
   input  logic                       valid,
   output logic                       ready,
   input  logic [DWIDTH-1:0]          din,
   output logic                       req,
   input  logic                       ack,
   output logic [DWIDTH-1:0]          dout,
   output logic                       busy,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       timeout_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);
   localparam bit FOUR_PHASE = (PHASES == PHASES_4);

   if (PHASES != PHASES_4 && PHASES != PHASES_2) begin : g_bad_phases
      $fatal(1, "PHASES must be 4 or 2");
   end
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $fatal(1, "DEPTH must be a power of 2 and at least 2");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $fatal(1, "SYNC_STAGES must be at least 2");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $fatal(1, "TIMEOUT_CYCLES must be at least 1");
   end

   state_t            state_q, state_d;
   logic              req_q, req_d;
   logic [DWIDTH-1:0] dout_q, dout_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]     count_q, count_d;
   logic [DWIDTH-1:0] mem_q [DEPTH];
   logic              ack_s;
   logic              push;
   logic              launch;

   cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_ack_sync (
      .clk   (clk1),
      .rst_n (rst1_n),
      .d     (ack),
      .q     (ack_s)
   );

   assign ready  = (count_q != LW'(DEPTH));
   assign push   = valid && ready;
   assign launch = (state_q == IDLE) && (count_q != '0);

   // Next-state for FIFO pointers, occupancy and the handshake FSM
   always_comb begin
      state_d  = state_q;
      req_d    = req_q;
      dout_d   = dout_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      case (state_q)
         IDLE: begin
            if (launch) begin
               dout_d   = mem_q[rd_ptr_q];
               rd_ptr_d = rd_ptr_q + PW'(1);
               if (FOUR_PHASE) begin
                  req_d   = 1'b1;
                  state_d = WAIT_ACK_HI;
               end else begin
                  req_d   = ~req_q;
                  state_d = WAIT_TOGGLE;
               end
            end
         end
         WAIT_ACK_HI: begin
            if (ack_s) begin
               req_d   = 1'b0;
               state_d = WAIT_ACK_LO;
            end
         end
         WAIT_ACK_LO: begin
            if (!ack_s) begin
               state_d = IDLE;
            end
         end
         WAIT_TOGGLE: begin
            if (ack_s == req_q) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      count_d = count_q + LW'(push) - LW'(launch);
   end

   // Register FSM state, handshake outputs and FIFO bookkeeping
   always_ff @(posedge clk1 or negedge rst1_n) begin
      if (!rst1_n) begin
         state_q  <= IDLE;
         req_q    <= 1'b0;
         dout_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         dout_q   <= dout_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // FIFO storage needs no reset; stale entries are unreachable once pointers clear
   always_ff @(posedge clk1) begin
      if (push) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   assign req   = req_q;
   assign dout  = dout_q;
   assign busy  = (state_q != IDLE);
   assign level = count_q;

`ifdef REQACK_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES+1);

   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic          timeout_err_q, timeout_err_d;

   // Count cycles spent in a wait state, saturating at the limit; the flag is sticky
   always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      if (state_d != state_q) begin
         tmo_cnt_d = '0;
      end else if (state_q != IDLE && tmo_cnt_q != TW'(TIMEOUT_CYCLES)) begin
         tmo_cnt_d = tmo_cnt_q + TW'(1);
      end
      timeout_err_d = timeout_err_q || (tmo_cnt_d == TW'(TIMEOUT_CYCLES));
   end

   // Register the wait counter and the timeout flag
   always_ff @(posedge clk1 or negedge rst1_n) begin
      if (!rst1_n) begin
         tmo_cnt_q     <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         tmo_cnt_q     <= tmo_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign timeout_err = timeout_err_q;
`else
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_req_ack_sender_fifo.sv
// Self-checking bench for req_ack_sender_fifo: a 4-phase instance and a
// 2-phase instance, each with a far-side ack model and a dout scoreboard.
// Timeout checks are compiled in when REQACK_TIMEOUT_EN is defined.
module tb_req_ack_sender_fifo;

   logic       clk1 = 1'b0;
   logic       rst1_n;

   logic       valid1, ready1, req1, ack1, busy1, terr1;
   logic [7:0] din1, dout1;
   logic [2:0] level1;

   logic       valid2, ready2, req2, ack2, busy2, terr2;
   logic [7:0] din2, dout2;
   logic [2:0] level2;

   int checks = 0;
   int errors = 0;

   logic [7:0] q1 [$];
   logic [7:0] q2 [$];
   int         launches1 = 0;
   int         toggles2 = 0;
   logic [2:0] reqSeq2 = 3'b000;
   logic       farEnable = 1'b1;

   typedef struct {
      logic       valid;
      logic [7:0] din;
      logic [2:0] expLevel;
      logic       expReady;
      logic       expReq;
      logic       expBusy;
   } vec_t;

   vec_t vecs [7];

   always #5 clk1 = ~clk1;

   req_ack_sender_fifo #(
      .DWIDTH(8), .DEPTH(4), .PHASES(4), .SYNC_STAGES(2), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk1(clk1), .rst1_n(rst1_n), .valid(valid1), .ready(ready1), .din(din1),
      .req(req1), .ack(ack1), .dout(dout1), .busy(busy1), .level(level1),
      .timeout_err(terr1)
   );

   req_ack_sender_fifo #(
      .DWIDTH(8), .DEPTH(4), .PHASES(2), .SYNC_STAGES(2), .TIMEOUT_CYCLES(16)
   ) dut2 (
      .clk1(clk1), .rst1_n(rst1_n), .valid(valid2), .ready(ready2), .din(din2),
      .req(req2), .ack(ack2), .dout(dout2), .busy(busy2), .level(level2),
      .timeout_err(terr2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Far side of the 4-phase link: ack follows req after 3 cycles
   initial begin
      int cnt = 0;
      ack1 = 1'b0;
      forever begin
         @(negedge clk1);
         if (!rst1_n) begin
            ack1 = 1'b0;
            cnt  = 0;
         end else if (!farEnable) begin
            cnt = 0;
         end else if (ack1 != req1) begin
            cnt++;
            if (cnt >= 3) begin
               ack1 = req1;
               cnt  = 0;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   // Far side of the 2-phase link: ack echoes req after 4 cycles
   initial begin
      int cnt = 0;
      ack2 = 1'b0;
      forever begin
         @(negedge clk1);
         if (!rst1_n) begin
            ack2 = 1'b0;
            cnt  = 0;
         end else if (ack2 != req2) begin
            cnt++;
            if (cnt >= 4) begin
               ack2 = req2;
               cnt  = 0;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   // Scoreboard for the 4-phase instance: compare dout on each req rise, hold while busy
   initial begin
      logic       prevReq = 1'b0;
      logic       prevBusy = 1'b0;
      logic [7:0] prevDout = 8'h00;
      forever begin
         @(negedge clk1);
         if (!rst1_n) begin
            prevReq  = 1'b0;
            prevBusy = 1'b0;
         end else begin
            if (req1 && !prevReq) begin
               launches1++;
               if (q1.size() == 0) begin
                  check("launch_unexpected_4p", 32'd1, 32'd0);
               end else begin
                  check("dout_order_4p", dout1, q1.pop_front());
               end
            end
            if (busy1 && prevBusy) begin
               check("dout_hold_4p", dout1, prevDout);
            end
         end
         prevReq  = req1;
         prevBusy = busy1;
         prevDout = dout1;
      end
   end

   // Scoreboard for the 2-phase instance: compare dout on each req toggle, hold while busy
   initial begin
      logic       prevReq = 1'b0;
      logic       prevBusy = 1'b0;
      logic [7:0] prevDout = 8'h00;
      forever begin
         @(negedge clk1);
         if (!rst1_n) begin
            prevReq  = 1'b0;
            prevBusy = 1'b0;
         end else begin
            if (req2 != prevReq) begin
               toggles2++;
               reqSeq2 = {reqSeq2[1:0], req2};
               if (q2.size() == 0) begin
                  check("launch_unexpected_2p", 32'd1, 32'd0);
               end else begin
                  check("dout_order_2p", dout2, q2.pop_front());
               end
            end
            if (busy2 && prevBusy) begin
               check("dout_hold_2p", dout2, prevDout);
            end
         end
         prevReq  = req2;
         prevBusy = busy2;
         prevDout = dout2;
      end
   end

   // Drive one upstream beat on the 4-phase instance and record it if accepted
   task automatic applyStimulus(input logic v, input logic [7:0] d);
      valid1 = v;
      din1   = d;
      if (v && ready1) q1.push_back(d);
   endtask

   task automatic checkOutput(input int idx);
      check($sformatf("vec%0d_level", idx), level1, vecs[idx].expLevel);
      check($sformatf("vec%0d_ready", idx), ready1, vecs[idx].expReady);
      check($sformatf("vec%0d_req", idx),   req1,   vecs[idx].expReq);
      check($sformatf("vec%0d_busy", idx),  busy1,  vecs[idx].expBusy);
   endtask

   task automatic waitIdle1(input int maxCycles, input string name);
      int n = 0;
      while ((busy1 || level1 != 3'd0) && n < maxCycles) begin
         @(negedge clk1);
         n++;
      end
      if (busy1 || level1 != 3'd0) check(name, 32'd0, 32'd1);
   endtask

   task automatic waitNotBusy1(input int maxCycles, input string name);
      int n = 0;
      while (busy1 && n < maxCycles) begin
         @(negedge clk1);
         n++;
      end
      if (busy1) check(name, 32'd0, 32'd1);
   endtask

   initial begin
      int         base;
      logic       sawFall;
      int         n;
      vecs[0] = '{1'b1, 8'h01, 3'd1, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 8'h02, 3'd1, 1'b1, 1'b1, 1'b1};
      vecs[2] = '{1'b1, 8'h03, 3'd2, 1'b1, 1'b1, 1'b1};
      vecs[3] = '{1'b1, 8'h04, 3'd3, 1'b1, 1'b1, 1'b1};
      vecs[4] = '{1'b1, 8'h05, 3'd4, 1'b0, 1'b1, 1'b1};
      vecs[5] = '{1'b1, 8'h06, 3'd4, 1'b0, 1'b1, 1'b1};
      vecs[6] = '{1'b0, 8'h00, 3'd4, 1'b0, 1'b1, 1'b1};

      rst1_n = 1'b0;
      valid1 = 1'b0; din1 = 8'h00;
      valid2 = 1'b0; din2 = 8'h00;
      repeat (3) @(negedge clk1);

      check("rst_req",   req1,   32'd0);
      check("rst_dout",  dout1,  32'd0);
      check("rst_busy",  busy1,  32'd0);
      check("rst_level", level1, 32'd0);
      check("rst_ready", ready1, 32'd1);
      check("rst_terr",  terr1,  32'd0);
      check("rst_req_2p", req2,  32'd0);
      rst1_n = 1'b1;
      repeat (2) @(negedge clk1);

      // 4-phase single transfer
      applyStimulus(1'b1, 8'hA5);
      @(negedge clk1);
      applyStimulus(1'b0, 8'h00);
      check("single_level_after_push", level1, 32'd1);
      check("single_req_after_push",   req1,   32'd0);
      @(negedge clk1);
      check("single_req_launch",   req1,   32'd1);
      check("single_dout_launch",  dout1,  32'hA5);
      check("single_level_launch", level1, 32'd0);
      check("single_busy_launch",  busy1,  32'd1);
      sawFall = 1'b0;
      n = 0;
      while (busy1 && n < 60) begin
         @(negedge clk1);
         if (busy1 && !req1) sawFall = 1'b1;
         n++;
      end
      check("single_req_fell", sawFall, 32'd1);
      check("single_busy_done", busy1, 32'd0);
      check("single_level_done", level1, 32'd0);

      // Burst with the far side stalled, table-driven
      base = launches1;
      farEnable = 1'b0;
      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i].valid, vecs[i].din);
         @(negedge clk1);
         checkOutput(i);
      end

      // Launch from full while upstream keeps pushing: the push is refused
      applyStimulus(1'b1, 8'h77);
      farEnable = 1'b1;
      waitNotBusy1(80, "full_wait_idle_timeout");
      check("full_idle_level", level1, 32'd4);
      check("full_idle_ready", ready1, 32'd0);
      @(negedge clk1);
      applyStimulus(1'b0, 8'h00);
      check("full_refused_level", level1, 32'd3);
      check("full_refused_busy",  busy1,  32'd1);
      waitIdle1(300, "burst_drain_timeout");
      applyStimulus(1'b1, 8'h06);
      @(negedge clk1);
      applyStimulus(1'b0, 8'h00);
      waitIdle1(100, "burst_last_timeout");
      check("burst_launch_count", launches1 - base, 32'd6);
      check("burst_queue_empty", q1.size(), 32'd0);

      // Simultaneous push and pop at level 2
      farEnable = 1'b0;
      applyStimulus(1'b1, 8'hC1);
      @(negedge clk1);
      applyStimulus(1'b1, 8'hC2);
      @(negedge clk1);
      applyStimulus(1'b1, 8'hC3);
      @(negedge clk1);
      applyStimulus(1'b0, 8'h00);
      check("pp_level_before", level1, 32'd2);
      farEnable = 1'b1;
      waitNotBusy1(80, "pp_wait_idle_timeout");
      check("pp_idle_level", level1, 32'd2);
      applyStimulus(1'b1, 8'hC4);
      @(negedge clk1);
      applyStimulus(1'b0, 8'h00);
      check("pp_level_same", level1, 32'd2);
      waitIdle1(300, "pp_drain_timeout");
      check("pp_queue_empty", q1.size(), 32'd0);

      // Reset in the middle of a transfer
      farEnable = 1'b0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 8'hD0 + 8'(i));
         @(negedge clk1);
      end
      applyStimulus(1'b0, 8'h00);
      check("mid_level_before_rst", level1, 32'd3);
      check("mid_busy_before_rst",  busy1,  32'd1);
      check("mid_req_before_rst",   req1,   32'd1);
      rst1_n = 1'b0;
      #1;
      check("mid_rst_req",   req1,   32'd0);
      check("mid_rst_level", level1, 32'd0);
      check("mid_rst_ready", ready1, 32'd1);
      check("mid_rst_busy",  busy1,  32'd0);
      check("mid_rst_dout",  dout1,  32'd0);
      q1.delete();
      repeat (2) @(negedge clk1);
      rst1_n = 1'b1;
      farEnable = 1'b1;
      repeat (2) @(negedge clk1);
      check("post_rst_idle", busy1, 32'd0);

      // 2-phase instance: three pushes back-to-back
      for (int i = 0; i < 3; i++) begin
         valid2 = 1'b1;
         din2   = 8'hB1 + 8'(i);
         if (ready2) q2.push_back(din2);
         @(negedge clk1);
      end
      valid2 = 1'b0;
      n = 0;
      while ((busy2 || level2 != 3'd0) && n < 300) begin
         @(negedge clk1);
         n++;
      end
      check("2p_drained", busy2 || level2 != 3'd0, 32'd0);
      check("2p_toggles", toggles2, 32'd3);
      check("2p_req_seq", reqSeq2, 32'b101);
      check("2p_req_final", req2, 32'd1);
      check("2p_queue_empty", q2.size(), 32'd0);

`ifdef REQACK_TIMEOUT_EN
      // Ack withheld: flag rises after 16 wait cycles and stays set
      farEnable = 1'b0;
      applyStimulus(1'b1, 8'hE1);
      @(negedge clk1);
      applyStimulus(1'b0, 8'h00);
      @(negedge clk1);
      check("tmo_req_launched", req1, 32'd1);
      check("tmo_flag_initial", terr1, 32'd0);
      n = 0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk1);
         if (terr1 && n == 0) n = k;
      end
      check("tmo_flag_cycle", n, 32'd16);
      farEnable = 1'b1;
      waitIdle1(100, "tmo_complete_timeout");
      check("tmo_flag_sticky", terr1, 32'd1);
      check("tmo_queue_empty", q1.size(), 32'd0);
`else
      check("terr_tied_low", terr1, 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
